// File: rtl/uart_tx.sv
// UART transmitter: drains a show-ahead byte FIFO, one byte per 8N1 frame, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shifter_reg, shifter_next;
    logic          tx_reg, tx_next;
    logic          done_reg, done_next;
    logic          baud_done;

`ifdef UART_TX_PARITY_EN
    logic parity_reg;

    // Parity is taken from the byte as popped, before the shifter starts consuming it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (fifo_rd_en) begin
            parity_reg <= ^fifo_rd_data;
        end
    end
`endif

    assign fifo_rd_en = rst_n && (state_reg == IDLE) && tx_en && !fifo_empty;
    assign baud_done  = (baud_reg == BAUD_MAX);

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shifter_next = shifter_reg;
        done_next    = 1'b0;
        tx_next      = 1'b1;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (fifo_rd_en) begin
                    state_next   = START;
                    shifter_next = fifo_rd_data;
                    bit_idx_next = 3'd0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    state_next = DATA;
                    baud_next  = '0;
                end
            end
            DATA: begin
                tx_next = shifter_reg[0];
                if (baud_done) begin
                    baud_next    = '0;
                    shifter_next = shifter_reg >> 1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = parity_reg;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // bit_idx wrapped to 0 after data bit 7 and now counts stop bits.
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx_reg == STOP_LAST) begin
                        state_next   = IDLE;
                        bit_idx_next = 3'd0;
                        done_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            shifter_reg <= 8'd0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shifter_reg <= shifter_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
        end
    end

    // The line lags the state by one cycle, giving the pop-to-start-bit gap.
    assign tx      = tx_reg;
    assign busy    = (state_reg != IDLE);
    assign tx_done = done_reg;

endmodule
